multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the ARMv8 (LEGv8 subset) core. It steps each instruction through fetch, decode, execute, memory and writeback. A single shared memory port is used for both fetch and data, with a request/ready handshake. Each cycle it produces the datapath strobes, including the 2-bit immediate-generator select. It sits between the instruction register/memory port and the existing register file, ALU and immediate generator.

---
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the LEGv8 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port and drives the datapath strobes every cycle.
// Ports:
//   CLK, Reset_L         clock, async active-low reset
//   Opcode[10:0]         instruction bits [31:21] from the IR
//   Zero                 ALU zero flag (used in EXEC for CBZ)
//   mem_ready            memory completes the current request
//   mem_req/mem_we/mem_sel  memory request, write, address select (0 PC, 1 ALU)
//   ir_we, pc_we, pc_src IR load, PC load, PC source (0 PC+4, 1 branch target)
//   imm_sel[1:0]         immediate generator select
//   alu_src, alu_op[3:0] ALU operand-B select and operation
//   reg2loc, reg_we, mem_to_reg  register-file controls
//   busy                 low only in HALT
//   illegal              sticky undecodable-opcode flag
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  imm_sel,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic        reg2loc,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI,
                            C_LDUR, C_STUR, C_CBZ, C_B, C_ILL} cls_t;

  state_t      state, nxt;
  cls_t        cls;
  logic        ex_alu_src, ex_reg2loc;
  logic [1:0]  ex_imm_sel;
  logic [3:0]  ex_alu_op;

  // Instruction class from the IR opcode field.
  always_comb begin
    cls = C_ILL;
    casez (Opcode)
      11'b10001011000: cls = C_ADD;
      11'b11001011000: cls = C_SUB;
      11'b10001010000: cls = C_AND;
      11'b10101010000: cls = C_ORR;
      11'b1001000100?: cls = C_ADDI;
      11'b1101000100?: cls = C_SUBI;
      11'b11111000010: cls = C_LDUR;
      11'b11111000000: cls = C_STUR;
      11'b10110100???: cls = C_CBZ;
      11'b000101?????: cls = C_B;
      default:         cls = C_ILL;
    endcase
  end

  // EXEC-phase ALU/immediate controls; reused in MEM/WB to keep operands stable.
  always_comb begin
    ex_alu_src = 1'b0;
    ex_imm_sel = 2'b00;
    ex_alu_op  = 4'b0000;
    ex_reg2loc = 1'b0;
    case (cls)
      C_ADD:  ex_alu_op = 4'b0010;
      C_SUB:  ex_alu_op = 4'b0110;
      C_AND:  ex_alu_op = 4'b0000;
      C_ORR:  ex_alu_op = 4'b0001;
      C_ADDI: begin ex_alu_src = 1'b1; ex_alu_op = 4'b0010; end
      C_SUBI: begin ex_alu_src = 1'b1; ex_alu_op = 4'b0110; end
      C_LDUR: begin ex_alu_src = 1'b1; ex_imm_sel = 2'b01; ex_alu_op = 4'b0010; end
      C_STUR: begin
        ex_alu_src = 1'b1; ex_imm_sel = 2'b01; ex_alu_op = 4'b0010; ex_reg2loc = 1'b1;
      end
      C_CBZ:  begin ex_imm_sel = 2'b11; ex_alu_op = 4'b0111; ex_reg2loc = 1'b1; end
      C_B:    ex_imm_sel = 2'b10;
      default: ;
    endcase
  end

  // State register and sticky illegal flag.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE && cls == C_ILL) illegal <= 1'b1;
    end
  end

  // Next state.
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: nxt = (cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_B, C_CBZ:     nxt = S_FETCH;
          C_LDUR, C_STUR: nxt = S_MEM;
          C_ILL:          nxt = S_FETCH; // unreachable while the IR is stable
          default:        nxt = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) nxt = (cls == C_STUR) ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // Strobes: Moore on state, qualified by the opcode class.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    reg2loc    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    busy       = (state != S_HALT);
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_EXEC: begin
        alu_src = ex_alu_src;
        imm_sel = ex_imm_sel;
        alu_op  = ex_alu_op;
        reg2loc = ex_reg2loc;
        if (cls == C_B || (cls == C_CBZ && Zero)) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls == C_STUR);
        alu_src = 1'b1;
        imm_sel = 2'b01;
        alu_op  = 4'b0010;
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls == C_LDUR);
        if (cls != C_LDUR) begin
          alu_src = ex_alu_src;
          imm_sel = ex_imm_sel;
          alu_op  = ex_alu_op;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        CLK = 1'b0, Reset_L = 1'b1;
  logic [10:0] Opcode = 11'd0;
  logic        Zero = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src;
  logic [1:0]  imm_sel;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        reg2loc, reg_we, mem_to_reg, busy, illegal;

  multicycle_ctrl dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_src(alu_src),
    .alu_op(alu_op), .reg2loc(reg2loc), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .busy(busy), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src;
    logic [1:0] imm_sel;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       reg2loc, reg_we, mem_to_reg, busy, illegal;
  } outs_t;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR, K_STUR, K_CBZ, K_B} kind_t;

  outs_t act;
  assign act = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, imm_sel, alu_src,
                alu_op, reg2loc, reg_we, mem_to_reg, busy, illegal};

  outs_t q[$];
  int vectors = 0, miscompares = 0;
  logic [10:0] ill_ops [5] = '{11'b11111111111, 11'b00000000000, 11'b10001011001,
                               11'b11111000001, 11'b10110101000};

  task automatic check(string nm, outs_t a, outs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %05h expected %05h", nm, $time, a, e);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge CLK) begin
    outs_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("cycle", act, e);
    end
  end

  function automatic logic rb();
    return logic'($urandom & 1);
  endfunction

  function automatic outs_t o_fetch(logic done);
    outs_t e = '0;
    e.mem_req = 1'b1; e.busy = 1'b1; e.ir_we = done; e.pc_we = done;
    return e;
  endfunction

  function automatic outs_t o_busy();
    outs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Build an opcode of the given kind, filling don't-care bits randomly.
  function automatic logic [10:0] mk_op(kind_t k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_ADD:  return 11'b10001011000;
      K_SUB:  return 11'b11001011000;
      K_AND:  return 11'b10001010000;
      K_ORR:  return 11'b10101010000;
      K_ADDI: return {10'b1001000100, r[0]};
      K_SUBI: return {10'b1101000100, r[0]};
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_CBZ:  return {8'b10110100, r[2:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  // One clock cycle of stimulus together with its expected outputs.
  task automatic cyc(logic rdy, logic z, outs_t e);
    @(posedge CLK); #1;
    mem_ready = rdy;
    Zero      = z;
    q.push_back(e);
  endtask

  // Reference behaviour of one instruction as a cycle-by-cycle list of strobes.
  // abort: stop while still waiting in MEM (caller resets).
  task automatic run_instr(kind_t k, logic [10:0] op, int nf, int nm, logic z, bit abort);
    outs_t e;
    logic  is_r, is_i, is_mem;
    is_r   = (k == K_ADD || k == K_SUB || k == K_AND || k == K_ORR);
    is_i   = (k == K_ADDI || k == K_SUBI);
    is_mem = (k == K_LDUR || k == K_STUR);
    repeat (nf) cyc(1'b0, rb(), o_fetch(1'b0));
    cyc(1'b1, rb(), o_fetch(1'b1));
    cyc(rb(), rb(), o_busy());
    Opcode = op;
    // EXEC
    e = o_busy();
    e.alu_src = is_i || is_mem;
    e.reg2loc = (k == K_STUR || k == K_CBZ);
    e.imm_sel = is_mem ? 2'b01 : (k == K_B) ? 2'b10 : (k == K_CBZ) ? 2'b11 : 2'b00;
    case (k)
      K_SUB, K_SUBI: e.alu_op = 4'b0110;
      K_AND, K_B:    e.alu_op = 4'b0000;
      K_ORR:         e.alu_op = 4'b0001;
      K_CBZ:         e.alu_op = 4'b0111;
      default:       e.alu_op = 4'b0010;
    endcase
    if (k == K_B || (k == K_CBZ && z)) begin e.pc_we = 1'b1; e.pc_src = 1'b1; end
    cyc(rb(), (k == K_CBZ) ? z : rb(), e);
    if (is_mem) begin
      outs_t m = o_busy();
      m.mem_req = 1'b1; m.mem_sel = 1'b1; m.mem_we = (k == K_STUR);
      m.alu_src = 1'b1; m.imm_sel = 2'b01; m.alu_op = 4'b0010;
      for (int i = 0; i <= nm; i++) begin
        if (abort && i == nm) return;
        cyc(i == nm, rb(), m);
      end
    end
    if (is_r || is_i || k == K_LDUR) begin
      outs_t w = o_busy();
      w.reg_we = 1'b1;
      w.mem_to_reg = (k == K_LDUR);
      if (k != K_LDUR) begin w.alu_src = e.alu_src; w.alu_op = e.alu_op; end
      cyc(rb(), rb(), w);
    end
  endtask

  // Asynchronous reset dropped mid-cycle; FETCH strobes must appear at once.
  task automatic do_reset();
    @(negedge CLK); #2;
    Reset_L = 1'b0;
    mem_ready = 1'b0;
    #1 check("async_reset", act, o_fetch(1'b0));
    @(posedge CLK); #1 check("reset_held", act, o_fetch(1'b0));
    @(negedge CLK); #1;
    Reset_L = 1'b1;
  endtask

  task automatic run_illegal(logic [10:0] op, int nf, int nh);
    outs_t h = '0;
    h.illegal = 1'b1;
    repeat (nf) cyc(1'b0, rb(), o_fetch(1'b0));
    cyc(1'b1, rb(), o_fetch(1'b1));
    cyc(rb(), rb(), o_busy());
    Opcode = op;
    repeat (nh) cyc(rb(), rb(), h);
    do_reset();
  endtask

  initial begin
    #1 Reset_L = 1'b0;
    #2 check("reset_state", act, o_fetch(1'b0));
    @(posedge CLK); @(negedge CLK); #1;
    Reset_L = 1'b1;

    // Directed cases
    run_instr(K_ADD,  11'b10001011000, 0, 0, 1'b0, 0);
    run_instr(K_LDUR, 11'b11111000010, 0, 3, 1'b0, 0);
    run_instr(K_CBZ,  mk_op(K_CBZ), 0, 0, 1'b1, 0);
    run_instr(K_CBZ,  mk_op(K_CBZ), 0, 0, 1'b0, 0);
    run_instr(K_B,    11'b00010100000, 0, 0, 1'b0, 0);
    run_instr(K_ADDI, mk_op(K_ADDI), 1, 0, 1'b0, 0);
    run_instr(K_STUR, 11'b11111000000, 2, 1, 1'b0, 0);
    run_illegal(11'b11111111111, 0, 4);
    run_instr(K_STUR, 11'b11111000000, 0, 2, 1'b0, 1);
    do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      int r = $urandom_range(0, 11);
      if (r >= 10)
        run_illegal(ill_ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(1, 4));
      else begin
        kind_t k = kind_t'(r);
        run_instr(k, mk_op(k), $urandom_range(0, 2), $urandom_range(0, 3), rb(), 0);
      end
    end

    repeat (3) @(posedge CLK);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
